// File: rtl/accent_metronome_if.sv
// ---------------------------------------------------------------------------
// accent_metronome_if
//   Bundles the tempo-control inputs and buzzer/status outputs of the
//   accent metronome so the control block and the metronome share one port.
//
//   Signals:
//     bpm            requested tempo (unsigned, clamped inside the metronome)
//     beats_per_bar  beats per bar; 0 and 1 both mean every beat is accented
//     play           level: 1 run, 0 stop
//     bell           square-wave buzzer drive
//     beat_pulse     one-clk strobe at each beat start
//     accent         1 while the current beat is beat 0
//     beat_idx       index of the current beat in the bar
//     period         active ticks per beat
//     busy           tempo divider running
//
//   Modports:
//     master  tempo controller side (drives bpm/beats_per_bar/play)
//     slave   metronome side (drives bell and status)
// ---------------------------------------------------------------------------
interface accent_metronome_if #(
    parameter int MEAS_W = 3
);
    logic [7:0]        bpm;
    logic [MEAS_W-1:0] beats_per_bar;
    logic              play;
    logic              bell;
    logic              beat_pulse;
    logic              accent;
    logic [MEAS_W-1:0] beat_idx;
    logic [23:0]       period;
    logic              busy;

    modport master (
        output bpm, beats_per_bar, play,
        input  bell, beat_pulse, accent, beat_idx, period, busy
    );

    modport slave (
        input  bpm, beats_per_bar, play,
        output bell, beat_pulse, accent, beat_idx, period, busy
    );
endinterface

// File: rtl/accent_metronome.sv
// ---------------------------------------------------------------------------
// accent_metronome
//   Metronome with bar accent. A prescaler turns clk into a timebase tick,
//   a sequential restoring divider converts the clamped tempo into a beat
//   period in ticks, and a two-state FSM counts ticks into beats and beats
//   into bars. Each beat starts a click: a square wave on bell that uses a
//   higher pitch on beat 0 of the bar.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    accent_metronome_if.slave (bpm, beats_per_bar, play in;
//            bell, beat_pulse, accent, beat_idx, period, busy out)
// ---------------------------------------------------------------------------
module accent_metronome #(
    parameter int CLK_DIV       = 2500,
    parameter int TICKS_PER_MIN = 600000,
    parameter int BPM_MIN       = 30,
    parameter int BPM_MAX       = 250,
    parameter int MEAS_W        = 3,
    parameter int CLICK_TICKS   = 400,
    parameter int TONE_DIV      = 5000,
    parameter int ACCENT_DIV    = 2500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    accent_metronome_if.slave    bus
);

    localparam int PRE_W    = $clog2(CLK_DIV + 1);
    localparam int CLK_W    = $clog2(CLICK_TICKS + 1);
    localparam int TONE_MAX = (TONE_DIV > ACCENT_DIV) ? TONE_DIV : ACCENT_DIV;
    localparam int TONE_W   = $clog2(TONE_MAX + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // Tempo clamp
    // ------------------------------------------------------------------
    logic [7:0] w_eff_bpm;

    always_comb begin
        w_eff_bpm = bus.bpm;
        if (bus.bpm < 8'(BPM_MIN)) begin
            w_eff_bpm = 8'(BPM_MIN);
        end else if (bus.bpm > 8'(BPM_MAX)) begin
            w_eff_bpm = 8'(BPM_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Restoring divider: TICKS_PER_MIN / latched bpm.
    // r_quo starts as the numerator and shifts left one bit per iteration,
    // collecting quotient bits in its LSB. Remainder stays below the
    // divisor, so 8 bits hold it and the shifted value needs 9.
    // Sequence: start clk, 24 iteration clks, one finish clk (25 busy clks).
    // ------------------------------------------------------------------
    logic [7:0]  r_bpm_lat;
    logic        r_busy;
    logic [4:0]  r_div_cnt;
    logic [23:0] r_quo;
    logic [7:0]  r_rem;
    logic [23:0] r_period_next;

    logic [8:0]  w_rem_sh;
    logic        w_rem_ge;
    logic [7:0]  w_rem_sub;

    assign w_rem_sh  = {r_rem, r_quo[23]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_bpm_lat});
    assign w_rem_sub = w_rem_sh[7:0] - r_bpm_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bpm_lat     <= '0;
            r_busy        <= 1'b0;
            r_div_cnt     <= '0;
            r_quo         <= '0;
            r_rem         <= '0;
            r_period_next <= '0;
        end else if (!r_busy) begin
            if (w_eff_bpm != r_bpm_lat) begin
                r_bpm_lat <= w_eff_bpm;
                r_busy    <= 1'b1;
                r_div_cnt <= '0;
                r_quo     <= 24'(TICKS_PER_MIN);
                r_rem     <= '0;
            end
        end else if (r_div_cnt == 5'd24) begin
            r_period_next <= r_quo;
            r_busy        <= 1'b0;
        end else begin
            r_quo     <= {r_quo[22:0], w_rem_ge};
            r_rem     <= w_rem_ge ? w_rem_sub : w_rem_sh[7:0];
            r_div_cnt <= r_div_cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Timebase prescaler; held in reset while stopped so each run starts
    // from a fresh tick phase.
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] r_presc;
    logic             w_tick;

    assign w_tick = bus.play && (r_presc == PRE_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!bus.play || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Beat FSM
    // ------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [23:0]       r_tick_cnt;
    logic [23:0]       r_period;
    logic              r_beat_pulse;
    logic              r_accent;
    logic [MEAS_W-1:0] r_beat_idx;

    logic              w_start;
    logic              w_beat_end;
    logic              w_beat;
    logic [MEAS_W:0]   w_idx_inc;
    logic [MEAS_W-1:0] w_idx_next;

    assign w_start    = (r_state == ST_IDLE) && bus.play && (r_period != 24'd0);
    assign w_beat_end = (r_state == ST_RUN) && w_tick
                        && (r_tick_cnt == r_period - 24'd1);
    assign w_beat     = w_start || w_beat_end;

    // Wrap compare is done one bit wider so beats_per_bar of 0 or 1 always
    // wraps and a shrunk bar wraps at the very next beat.
    assign w_idx_inc  = {1'b0, r_beat_idx} + 1'b1;
    assign w_idx_next = (w_idx_inc >= {1'b0, bus.beats_per_bar})
                        ? '0 : w_idx_inc[MEAS_W-1:0];

    // While idle the period follows the divider result directly; while
    // running a new period is only taken at a beat boundary so the beat in
    // flight keeps its spacing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tick_cnt   <= '0;
            r_period     <= '0;
            r_beat_pulse <= 1'b0;
            r_accent     <= 1'b0;
            r_beat_idx   <= '0;
        end else begin
            r_beat_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_period   <= r_period_next;
                    r_tick_cnt <= '0;
                    r_accent   <= 1'b0;
                    r_beat_idx <= '0;
                    if (w_start) begin
                        r_state      <= ST_RUN;
                        r_beat_pulse <= 1'b1;
                        r_accent     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus.play) begin
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                        r_accent   <= 1'b0;
                        r_beat_idx <= '0;
                    end else if (w_beat_end) begin
                        r_tick_cnt   <= '0;
                        r_beat_pulse <= 1'b1;
                        r_beat_idx   <= w_idx_next;
                        r_accent     <= (w_idx_next == '0);
                        r_period     <= r_period_next;
                    end else if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 24'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Click generator. A beat restarts the click and the tone counter, so
    // bell always starts low and first toggles after one half-period.
    // ------------------------------------------------------------------
    logic              r_clicking;
    logic [CLK_W-1:0]  r_click_cnt;
    logic [TONE_W-1:0] r_tone_cnt;
    logic              r_bell;
    logic [TONE_W-1:0] w_tone_last;

    assign w_tone_last = r_accent ? TONE_W'(ACCENT_DIV - 1) : TONE_W'(TONE_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clicking  <= 1'b0;
            r_click_cnt <= '0;
            r_tone_cnt  <= '0;
            r_bell      <= 1'b0;
        end else if (w_beat) begin
            r_clicking  <= 1'b1;
            r_click_cnt <= '0;
            r_tone_cnt  <= '0;
            r_bell      <= 1'b0;
        end else if (!(r_state == ST_RUN && bus.play) || !r_clicking) begin
            r_clicking  <= 1'b0;
            r_click_cnt <= '0;
            r_tone_cnt  <= '0;
            r_bell      <= 1'b0;
        end else if (w_tick && (r_click_cnt == CLK_W'(CLICK_TICKS - 1))) begin
            r_clicking  <= 1'b0;
            r_click_cnt <= '0;
            r_tone_cnt  <= '0;
            r_bell      <= 1'b0;
        end else begin
            if (w_tick) begin
                r_click_cnt <= r_click_cnt + 1'b1;
            end
            if (r_tone_cnt == w_tone_last) begin
                r_tone_cnt <= '0;
                r_bell     <= ~r_bell;
            end else begin
                r_tone_cnt <= r_tone_cnt + 1'b1;
            end
        end
    end

    assign bus.bell       = r_bell;
    assign bus.beat_pulse = r_beat_pulse;
    assign bus.accent     = r_accent;
    assign bus.beat_idx   = r_beat_idx;
    assign bus.period     = r_period;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_accent_metronome.sv
// ---------------------------------------------------------------------------
// tb_accent_metronome
//   Directed bench for accent_metronome. One instance uses the default
//   parameters (divider results and clamping); a second uses small timing
//   parameters so beats, bar counting and click tones fit in a short run.
// ---------------------------------------------------------------------------
module tb_accent_metronome;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    accent_metronome_if #(.MEAS_W(3)) dIf ();
    accent_metronome_if #(.MEAS_W(3)) sIf ();

    accent_metronome u_dflt (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dIf)
    );

    accent_metronome #(
        .CLK_DIV       (1),
        .TICKS_PER_MIN (6000),
        .CLICK_TICKS   (10),
        .TONE_DIV      (4),
        .ACCENT_DIV    (2)
    ) u_sim (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sIf)
    );

    int   total = 0;
    int   bad   = 0;

    int   cyc;
    int   nextPulse;
    int   lastPulse;
    int   pendPeriod;
    int   expIdx;
    int   bpbModel;
    bit   seenFirst;
    int   busyCnt;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] bpm, input logic [2:0] bpb,
                                 input logic play);
        sIf.bpm           = bpm;
        sIf.beats_per_bar = bpb;
        sIf.play          = play;
        bpbModel          = int'(bpb);
    endtask

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    // Waits for the selected instance's divider to start and finish.
    task automatic waitDivDone(input bit useDflt, input string tag);
        int  n;
        bit  b;
        n = 0;
        do begin
            tickClk();
            n++;
            b = useDflt ? dIf.busy : sIf.busy;
        end while (!b && n < 10);
        while (b && n < 200) begin
            tickClk();
            n++;
            b = useDflt ? dIf.busy : sIf.busy;
        end
        checkOutput({tag, " busy_timeout"}, 32'(b), 32'(0));
    endtask

    // Resets the beat model for a fresh start of play.
    task automatic restartModel();
        cyc       = 0;
        nextPulse = 1;
        lastPulse = -1000;
        seenFirst = 1'b0;
        expIdx    = 0;
    endtask

    // Steps n clks on the small instance, predicting beat_pulse and bell
    // every clk and beat_idx/accent at every beat start.
    task automatic runCheck(input int n);
        bit expPulse;
        bit expAccent;
        bit expBell;
        int s;
        for (int i = 0; i < n; i++) begin
            tickClk();
            cyc++;
            expPulse = (cyc == nextPulse);
            if (expPulse) begin
                if (seenFirst) begin
                    expIdx = (expIdx + 1 >= bpbModel) ? 0 : expIdx + 1;
                end else begin
                    expIdx = 0;
                end
                seenFirst = 1'b1;
                lastPulse = cyc;
                nextPulse = cyc + pendPeriod;
            end
            expAccent = (expIdx == 0);
            s = cyc - lastPulse;
            if (s < 10) begin
                expBell = expAccent ? (((s / 2) % 2) != 0) : (((s / 4) % 2) != 0);
            end else begin
                expBell = 1'b0;
            end
            checkOutput("beat_pulse", 32'(sIf.beat_pulse), 32'(expPulse));
            checkOutput("bell", 32'(sIf.bell), 32'(expBell));
            if (expPulse) begin
                checkOutput("beat_idx", 32'(sIf.beat_idx), 32'(expIdx));
                checkOutput("accent", 32'(sIf.accent), 32'(expAccent));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n             = 1'b0;
        dIf.bpm           = 8'd60;
        dIf.beats_per_bar = 3'd4;
        dIf.play          = 1'b0;
        applyStimulus(8'd60, 3'd4, 1'b0);
        restartModel();
        pendPeriod = 100;

        repeat (3) tickClk();
        checkOutput("rst dflt period", 32'(dIf.period), 32'(0));
        checkOutput("rst dflt busy", 32'(dIf.busy), 32'(0));
        checkOutput("rst sim bell", 32'(sIf.bell), 32'(0));
        checkOutput("rst sim beat_pulse", 32'(sIf.beat_pulse), 32'(0));
        checkOutput("rst sim accent", 32'(sIf.accent), 32'(0));
        checkOutput("rst sim beat_idx", 32'(sIf.beat_idx), 32'(0));
        checkOutput("rst sim period", 32'(sIf.period), 32'(0));

        // Divider kicks off at the first edge after release.
        rst_n   = 1'b1;
        busyCnt = 0;
        for (int i = 0; i < 100; i++) begin
            tickClk();
            if (dIf.busy) busyCnt++;
            else break;
        end
        checkOutput("busy cycles", 32'(busyCnt), 32'(25));
        tickClk();
        checkOutput("dflt period 60bpm", 32'(dIf.period), 32'(10000));
        checkOutput("sim period 60bpm", 32'(sIf.period), 32'(100));

        // Clamping on the default instance.
        dIf.bpm = 8'd10;
        waitDivDone(1'b1, "clamp low");
        tickClk();
        checkOutput("dflt period bpm10", 32'(dIf.period), 32'(20000));
        dIf.bpm = 8'd30;
        repeat (3) tickClk();
        checkOutput("no redivide at same eff bpm", 32'(dIf.busy), 32'(0));
        checkOutput("dflt period bpm30", 32'(dIf.period), 32'(20000));
        dIf.bpm = 8'd255;
        waitDivDone(1'b1, "clamp high");
        tickClk();
        checkOutput("dflt period bpm255", 32'(dIf.period), 32'(2400));

        // Run at 60 bpm, 4 beats per bar.
        applyStimulus(8'd60, 3'd4, 1'b1);
        restartModel();
        pendPeriod = 100;
        runCheck(430);

        // Tempo change mid-beat: beat in flight keeps 100, then 50.
        applyStimulus(8'd120, 3'd4, 1'b1);
        pendPeriod = 50;
        runCheck(230);
        checkOutput("sim period 120bpm", 32'(sIf.period), 32'(50));

        // beats_per_bar 0: every beat accented.
        applyStimulus(8'd120, 3'd0, 1'b1);
        runCheck(120);

        // Back to 4, then shrink to 2 while beat_idx is 3.
        applyStimulus(8'd120, 3'd4, 1'b1);
        runCheck(130);
        applyStimulus(8'd120, 3'd2, 1'b1);
        runCheck(nextPulse - cyc + 3);
        checkOutput("bell high before stop", 32'(sIf.bell), 32'(1));

        // Stop mid-click.
        applyStimulus(8'd120, 3'd2, 1'b0);
        tickClk();
        checkOutput("stop bell", 32'(sIf.bell), 32'(0));
        checkOutput("stop beat_pulse", 32'(sIf.beat_pulse), 32'(0));
        checkOutput("stop accent", 32'(sIf.accent), 32'(0));
        checkOutput("stop beat_idx", 32'(sIf.beat_idx), 32'(0));
        for (int i = 0; i < 3; i++) begin
            tickClk();
            checkOutput("idle beat_pulse", 32'(sIf.beat_pulse), 32'(0));
            checkOutput("idle bell", 32'(sIf.bell), 32'(0));
        end

        // Resume restarts at beat 0.
        applyStimulus(8'd120, 3'd2, 1'b1);
        restartModel();
        runCheck(60);

        // Reset asynchronously while running and dividing.
        applyStimulus(8'd200, 3'd2, 1'b1);
        runCheck(5);
        checkOutput("busy before abort", 32'(sIf.busy), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst bell", 32'(sIf.bell), 32'(0));
        checkOutput("async rst beat_idx", 32'(sIf.beat_idx), 32'(0));
        checkOutput("async rst accent", 32'(sIf.accent), 32'(0));
        checkOutput("async rst period", 32'(sIf.period), 32'(0));
        checkOutput("async rst busy", 32'(sIf.busy), 32'(0));
        checkOutput("async rst dflt period", 32'(dIf.period), 32'(0));
        applyStimulus(8'd200, 3'd2, 1'b0);
        tickClk();
        rst_n = 1'b1;
        waitDivDone(1'b0, "redivide");
        tickClk();
        checkOutput("sim period 200bpm", 32'(sIf.period), 32'(30));
        checkOutput("dflt period after rst", 32'(dIf.period), 32'(2400));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
